// File: rtl/idma_mfmap_raddr_gen.sv
// Multi-feature-map read-address generator: interleaves K base addresses over L stride
// steps into the read address FIFO, with abort, done pulse and config error detection.
module idma_mfmap_raddr_gen #(
    parameter int NUM_FMAP     = 4,
    parameter int AXI_ADDR_WID = 32,
    parameter int GAP_WID      = 16,
    parameter int LOOP_WID     = 16,
    parameter int SEL_WID      = 4
) (
    input  logic                             cclk,
    input  logic                             rst_n,
    input  logic                             cfg_start,
    input  logic                             cfg_abort,
    input  logic [SEL_WID-1:0]               cfg_fmap_num,
    input  logic [NUM_FMAP*AXI_ADDR_WID-1:0] cfg_base_addr,
    input  logic [GAP_WID-1:0]               cfg_addr_gap,
    input  logic [LOOP_WID-1:0]              cfg_loop_num,
    input  logic [31:0]                      cfg_rd_num,
    input  logic                             afifo_full,
    output logic                             req_valid,
    output logic [AXI_ADDR_WID-1:0]          req_addr,
    output logic [31:0]                      req_num,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err,
    output logic [LOOP_WID+SEL_WID-1:0]      req_cnt
);

    localparam int IDX_WID = (NUM_FMAP > 1) ? $clog2(NUM_FMAP) : 1;
    localparam int CNT_WID = LOOP_WID + SEL_WID;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t                  r_state;
    logic [AXI_ADDR_WID-1:0] r_base [NUM_FMAP];
    logic [AXI_ADDR_WID-1:0] w_cfg_base [NUM_FMAP];
    logic [AXI_ADDR_WID-1:0] r_offset;
    logic [AXI_ADDR_WID-1:0] r_req_addr;
    logic [GAP_WID-1:0]      r_gap;
    logic [IDX_WID-1:0]      r_fmap_idx;
    logic [IDX_WID-1:0]      r_last_idx;
    logic [LOOP_WID-1:0]     r_loop_idx;
    logic [LOOP_WID-1:0]     r_loop_last;
    logic [31:0]             r_req_num;
    logic [CNT_WID-1:0]      r_req_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cfg_err;

    logic                    w_cfg_legal;
    logic                    w_push;
    logic                    w_map_wrap;
    logic                    w_job_end;
    logic [IDX_WID-1:0]      w_idx_inc;
    logic [AXI_ADDR_WID-1:0] w_offset_next;
    logic [AXI_ADDR_WID-1:0] w_addr_next;

    for (genvar gi = 0; gi < NUM_FMAP; gi++) begin : g_slot
        assign w_cfg_base[gi] = cfg_base_addr[gi*AXI_ADDR_WID +: AXI_ADDR_WID];
    end

    assign w_cfg_legal = (cfg_fmap_num != '0)
                      && ({1'b0, cfg_fmap_num} <= (SEL_WID+1)'(NUM_FMAP))
                      && (cfg_loop_num != '0);

    // Abort suppresses the push in the same cycle so no request leaks past it.
    assign w_push        = (r_state == S_ISSUE) && !afifo_full && !cfg_abort;
    assign w_map_wrap    = (r_fmap_idx == r_last_idx);
    assign w_job_end     = w_map_wrap && (r_loop_idx == r_loop_last);
    assign w_idx_inc     = r_fmap_idx + IDX_WID'(1);
    assign w_offset_next = r_offset + AXI_ADDR_WID'(r_gap);
    // Address for the following push is prepared a cycle early so req_addr is a register.
    assign w_addr_next   = w_map_wrap ? (r_base[0] + w_offset_next)
                                      : (r_base[w_idx_inc] + r_offset);

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NUM_FMAP; i++) r_base[i] <= '0;
            r_offset    <= '0;
            r_req_addr  <= '0;
            r_gap       <= '0;
            r_fmap_idx  <= '0;
            r_last_idx  <= '0;
            r_loop_idx  <= '0;
            r_loop_last <= '0;
            r_req_num   <= '0;
            r_req_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        if (w_cfg_legal) begin
                            for (int i = 0; i < NUM_FMAP; i++) r_base[i] <= w_cfg_base[i];
                            r_req_addr  <= w_cfg_base[0];
                            r_gap       <= cfg_addr_gap;
                            r_last_idx  <= IDX_WID'(cfg_fmap_num - SEL_WID'(1));
                            r_loop_last <= cfg_loop_num - LOOP_WID'(1);
                            r_req_num   <= cfg_rd_num;
                            r_offset    <= '0;
                            r_fmap_idx  <= '0;
                            r_loop_idx  <= '0;
                            r_req_cnt   <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cfg_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_push) begin
                        r_req_cnt  <= r_req_cnt + CNT_WID'(1);
                        r_req_addr <= w_addr_next;
                        if (w_map_wrap) begin
                            r_fmap_idx <= '0;
                            r_offset   <= w_offset_next;
                            r_loop_idx <= r_loop_idx + LOOP_WID'(1);
                        end else begin
                            r_fmap_idx <= w_idx_inc;
                        end
                        if (w_job_end) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_valid = w_push;
    assign req_addr  = r_req_addr;
    assign req_num   = r_req_num;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign req_cnt   = r_req_cnt;

endmodule

// File: doc/idma_mfmap_raddr_gen.md
# idma_mfmap_raddr_gen

Parametrised multi-feature-map read-address generator for the iDMA read channel, in the cclk domain ahead of the read address FIFO. Given up to NUM_FMAP base addresses, a stride and a loop count, it issues interleaved read requests (fmap0, fmap1, … fmapK-1, then each base plus stride, …) into the address FIFO under full backpressure. It generalises the two-map residual address generator to N maps, with an explicit done pulse, an abort, and configuration error detection.

## Interface
- NUM_FMAP, 4, number of base-address slots (2..8)
- AXI_ADDR_WID, 32, address width
- GAP_WID, 16, stride width
- LOOP_WID, 16, loop-count width
- SEL_WID, 4, width of cfg_fmap_num
- cclk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; latches all cfg_* inputs
- cfg_abort  in  1  one-cycle abort pulse
- cfg_fmap_num  in  SEL_WID  number of maps used, K (1..NUM_FMAP)
- cfg_base_addr  in  NUM_FMAP*AXI_ADDR_WID  base addresses; slot i at bits [i*AXI_ADDR_WID +: AXI_ADDR_WID]
- cfg_addr_gap  in  GAP_WID  byte stride added per loop
- cfg_loop_num  in  LOOP_WID  loop count, L (≥1)
- cfg_rd_num  in  32  word count attached to every request
- afifo_full  in  1  address FIFO full (source side)
- req_valid  out  1  push strobe to the address FIFO
- req_addr  out  AXI_ADDR_WID  request address
- req_num  out  32  request word count (latched cfg_rd_num)
- busy  out  1  high in ISSUE
- done  out  1  one-cycle pulse after the last push
- cfg_err  out  1  one-cycle pulse on an illegal start
- req_cnt  out  LOOP_WID+SEL_WID  pushes issued in the current job

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - On cfg_start with a legal configuration: latch the configuration, clear fmap_idx, offset and req_cnt, and go to ISSUE.
  - Legal means 1 ≤ cfg_fmap_num ≤ NUM_FMAP and cfg_loop_num ≠ 0.
  - On an illegal configuration: pulse cfg_err, stay in IDLE, latch nothing.
- ISSUE:
  - req_valid = ~afifo_full (combinational). req_addr = base[fmap_idx] + offset, truncated mod 2^AXI_ADDR_WID.
  - On each push, fmap_idx increments and req_cnt increments.
  - When fmap_idx = K-1 on a push: fmap_idx wraps to 0, offset += zero-extended gap, and loop_idx increments.
  - The push with loop_idx = L-1 and fmap_idx = K-1 is the last one; the FSM then goes to DONE.
- DONE: done = 1 for one cycle, then return to IDLE. busy = 0 in DONE.
- The job issues exactly K*L pushes.
- Offset is a running accumulator; no multiplier is used.
- cfg_start while not in IDLE is ignored, and the latched configuration is unchanged.
- cfg_abort in ISSUE:
  - No push that cycle (req_valid is forced to 0).
  - Next state is IDLE; no done pulse. req_cnt holds its value.
- cfg_abort in IDLE or DONE has no effect; DONE still completes.
- cfg_abort together with cfg_start in IDLE: the abort wins and no job starts.

## Timing
- Reset values: state IDLE; req_valid, busy, done, cfg_err = 0; req_addr, req_num, req_cnt = 0.
- req_addr and req_num come from registers, so they are stable whenever req_valid is high.
- Latency:
  - cfg_start at cycle 0 → busy and the first possible push at cycle 1.
  - Last push at cycle n → done at cycle n+1 → IDLE at n+2; a new cfg_start is accepted at n+2.
- With no backpressure, one push per cycle: K*L pushes occupy cycles 1..K*L, and done is at cycle K*L+1.
- afifo_full high: req_valid = 0 and all counters hold. Issue resumes in the same cycle full drops.
- cfg_err is asserted in the cycle after the illegal cfg_start.
- rst_n asserted mid-job: immediate return to IDLE with all outputs at reset values; no done pulse.

## Test plan
- Basic: NUM_FMAP=4, K=2, bases 0x1000/0x8000, gap 0x100, L=3, rd_num 16, no backpressure → pushes at cycles 1–6 with addresses 0x1000, 0x8000, 0x1100, 0x8100, 0x1200, 0x8200, all req_num=16; done at cycle 7; req_cnt=6.
- Backpressure: same job, afifo_full high during cycles 2–4 → the address sequence is unchanged, no push during full, last push at cycle 9, done at cycle 10.
- Full K: K=4, bases 0x0/0x400/0x800/0xC00, gap 0x40, L=2 → 8 pushes 0x0, 0x400, 0x800, 0xC00, 0x40, 0x440, 0x840, 0xC40; done once.
- Wrap: K=1, base 0xFFFF_FF80, gap 0x100, L=2 → addresses 0xFFFF_FF80 then 0x0000_0080.
- Errors: cfg_fmap_num=0, cfg_fmap_num=5 (NUM_FMAP=4), and cfg_loop_num=0 → each gives one cfg_err pulse, no req_valid, busy stays 0. A cfg_start issued mid-job is ignored.
- Abort and reset: abort after 3 pushes of the basic job → no further push, no done, busy drops next cycle, req_cnt=3. A new start then issues the full 6 pushes. rst_n pulsed mid-job → all outputs are 0 and no done pulse.
